// File: rtl/approx_mult_pkg.sv
// rtl/approx_mult_pkg.sv - shared types and sizing for the approximate multiplier error monitor
package approx_mult_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 17;

  // The ED sum needs 2*WIDTH bits per sample plus CNT_W bits of growth for a full batch.
  function automatic int sum_w(input int width, input int cnt_w);
    return 2 * width + cnt_w;
  endfunction

endpackage

// File: rtl/approx_mult_err_monitor_err_dist_stage.sv
// rtl/approx_mult_err_monitor_err_dist_stage.sv - two-stage exact product and error distance
module err_dist_stage
  import approx_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2*WIDTH-1:0]   r,
  output logic                 s1_valid,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   out_ed,
  output logic [WIDTH-1:0]     out_a,
  output logic [WIDTH-1:0]     out_b
);

  localparam int PW = 2 * WIDTH;

  logic             s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d, s2_a_q, s2_a_d, s2_b_q, s2_b_d;
  logic [PW-1:0]    s1_r_q, s1_r_d, s2_ed_q, s2_ed_d;
  logic [PW-1:0]    prod, ed;

  always_comb begin
    prod = {{WIDTH{1'b0}}, s1_a_q} * {{WIDTH{1'b0}}, s1_b_q};
    ed   = (prod >= s1_r_q) ? (prod - s1_r_q) : (s1_r_q - prod);

    s1_v_d  = in_valid;
    s1_a_d  = s1_a_q;
    s1_b_d  = s1_b_q;
    s1_r_d  = s1_r_q;
    s2_v_d  = s1_v_q;
    s2_a_d  = s2_a_q;
    s2_b_d  = s2_b_q;
    s2_ed_d = s2_ed_q;
    // Data registers only move with a valid sample; valids alone carry the pipeline state.
    if (in_valid) begin
      s1_a_d = a;
      s1_b_d = b;
      s1_r_d = r;
    end
    if (s1_v_q) begin
      s2_a_d  = s1_a_q;
      s2_b_d  = s1_b_q;
      s2_ed_d = ed;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
    end
    s1_a_q  <= s1_a_d;
    s1_b_q  <= s1_b_d;
    s1_r_q  <= s1_r_d;
    s2_a_q  <= s2_a_d;
    s2_b_q  <= s2_b_d;
    s2_ed_q <= s2_ed_d;
  end

  assign s1_valid  = s1_v_q;
  assign out_valid = s2_v_q;
  assign out_ed    = s2_ed_q;
  assign out_a     = s2_a_q;
  assign out_b     = s2_b_q;

endmodule

// File: rtl/approx_mult_err_monitor.sv
// rtl/approx_mult_err_monitor.sv - batch FSM and error statistics accumulators
module approx_mult_err_monitor
  import approx_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int SUM_W = sum_w(WIDTH, CNT_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     n_samples,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2*WIDTH-1:0]   R,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [SUM_W-1:0]     sum_ed,
  output logic [2*WIDTH-1:0]   max_ed,
  output logic [WIDTH-1:0]     max_a,
  output logic [WIDTH-1:0]     max_b
);

  localparam int PW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d, acc_q, acc_d, err_cnt_q, err_cnt_d;
  logic             in_ready_q, in_ready_d, busy_q, busy_d, done_q, done_d;
  logic [SUM_W-1:0] sum_ed_q, sum_ed_d;
  logic [PW-1:0]    max_ed_q, max_ed_d;
  logic [WIDTH-1:0] max_a_q, max_a_d, max_b_q, max_b_d;

  logic             xfer, s1_valid, s2_valid;
  logic [PW-1:0]    s2_ed;
  logic [WIDTH-1:0] s2_a, s2_b;

  assign xfer = in_valid && in_ready_q;

  err_dist_stage #(.WIDTH(WIDTH)) u_stage (
    .clk      (clk),
    .rst      (rst),
    .in_valid (xfer),
    .a        (A),
    .b        (B),
    .r        (R),
    .s1_valid (s1_valid),
    .out_valid(s2_valid),
    .out_ed   (s2_ed),
    .out_a    (s2_a),
    .out_b    (s2_b)
  );

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    acc_d      = acc_q;
    in_ready_d = in_ready_q;
    err_cnt_d  = err_cnt_q;
    sum_ed_d   = sum_ed_q;
    max_ed_d   = max_ed_q;
    max_a_d    = max_a_q;
    max_b_d    = max_b_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          n_d        = n_samples;
          acc_d      = '0;
          err_cnt_d  = '0;
          sum_ed_d   = '0;
          max_ed_d   = '0;
          max_a_d    = '0;
          max_b_d    = '0;
          state_d    = (n_samples == '0) ? DRAIN : RUN;
          in_ready_d = (n_samples != '0);
        end
      end
      RUN: begin
        if (xfer) begin
          acc_d = acc_q + CNT_W'(1);
          if (acc_q + CNT_W'(1) == n_q) begin
            state_d    = DRAIN;
            in_ready_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (!s1_valid && !s2_valid) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    // The pipeline is empty whenever start is honoured, so clearing and accumulating never collide.
    if (s2_valid) begin
      sum_ed_d = sum_ed_q + {{(SUM_W-PW){1'b0}}, s2_ed};
      if (s2_ed != '0) err_cnt_d = err_cnt_q + CNT_W'(1);
      if (s2_ed > max_ed_q) begin
        max_ed_d = s2_ed;
        max_a_d  = s2_a;
        max_b_d  = s2_b;
      end
    end

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      acc_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_cnt_q  <= '0;
      sum_ed_q   <= '0;
      max_ed_q   <= '0;
      max_a_q    <= '0;
      max_b_q    <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      acc_q      <= acc_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_cnt_q  <= err_cnt_d;
      sum_ed_q   <= sum_ed_d;
      max_ed_q   <= max_ed_d;
      max_a_q    <= max_a_d;
      max_b_q    <= max_b_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err_cnt  = err_cnt_q;
  assign sum_ed   = sum_ed_q;
  assign max_ed   = max_ed_q;
  assign max_a    = max_a_q;
  assign max_b    = max_b_q;

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// tb/tb_approx_mult_err_monitor.sv - directed scoreboard bench for approx_mult_err_monitor
module tb_approx_mult_err_monitor;
  import approx_mult_pkg::*;

  localparam int WIDTH = DEF_WIDTH;
  localparam int CNT_W = DEF_CNT_W;
  localparam int SUM_W = sum_w(WIDTH, CNT_W);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [CNT_W-1:0]   n_samples = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [WIDTH-1:0]   a = '0;
  logic [WIDTH-1:0]   b = '0;
  logic [2*WIDTH-1:0] r = '0;
  logic               busy, done;
  logic [CNT_W-1:0]   err_cnt;
  logic [SUM_W-1:0]   sum_ed;
  logic [2*WIDTH-1:0] max_ed;
  logic [WIDTH-1:0]   max_a, max_b;

  approx_mult_err_monitor dut (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b), .R(r),
    .busy(busy), .done(done), .err_cnt(err_cnt), .sum_ed(sum_ed),
    .max_ed(max_ed), .max_a(max_a), .max_b(max_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     due;
    longint sum;
    longint err;
    longint mx;
    longint ma;
    longint mb;
  } snap_t;

  snap_t  sq[$];
  int     sa[$], sb[$], sr[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     last_xfer = -1;
  int     done_cyc = -1;
  int     n_xfer = 0;
  bit     ready_seen = 0;
  bit     prev_done = 0;
  longint m_sum, m_err, m_max, m_a, m_b;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_sum = 0; m_err = 0; m_max = 0; m_a = 0; m_b = 0;
  endtask

  task automatic tick();
    logic   xfer;
    longint p, ed;
    snap_t  s;
    xfer = (in_valid === 1'b1) && (in_ready === 1'b1);
    if (in_ready === 1'b1) ready_seen = 1;
    @(posedge clk);
    cyc++;
    #1;
    if (done === 1'b1 && !prev_done) done_cyc = cyc;
    prev_done = (done === 1'b1);
    if (rst) begin
      sq.delete();
    end else if (xfer) begin
      p  = longint'(a) * longint'(b);
      ed = (p >= longint'(r)) ? p - longint'(r) : longint'(r) - p;
      m_sum += ed;
      if (ed != 0) m_err++;
      if (ed > m_max) begin
        m_max = ed; m_a = a; m_b = b;
      end
      n_xfer++;
      last_xfer = cyc;
      s = '{due: cyc + 2, sum: m_sum, err: m_err, mx: m_max, ma: m_a, mb: m_b};
      sq.push_back(s);
    end
    while (sq.size() > 0 && sq[0].due == cyc) begin
      s = sq.pop_front();
      chk("pipe_sum_ed", sum_ed, s.sum);
      chk("pipe_err_cnt", err_cnt, s.err);
      chk("pipe_max_ed", max_ed, s.mx);
      chk("pipe_max_a", max_a, s.ma);
      chk("pipe_max_b", max_b, s.mb);
    end
  endtask

  task automatic start_batch(input int n);
    start = 1'b1;
    n_samples = CNT_W'(n);
    model_clear();
    n_xfer = 0;
    done_cyc = -1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_in_ready", in_ready, (n != 0));
    chk("start_sum_clr", sum_ed, 0);
    chk("start_err_clr", err_cnt, 0);
    chk("start_max_clr", max_ed, 0);
  endtask

  task automatic feed();
    for (int i = 0; i < sa.size(); i++) begin
      int k;
      bit took;
      k = 0;
      took = 0;
      a = WIDTH'(sa[i]);
      b = WIDTH'(sb[i]);
      r = (2*WIDTH)'(sr[i]);
      in_valid = 1'b1;
      while (!took && k < 20) begin
        took = (in_ready === 1'b1);
        tick();
        k++;
      end
      if (!took) chk("xfer_timeout", 0, 1);
    end
    in_valid = 1'b0;
    sa.delete(); sb.delete(); sr.delete();
  endtask

  task automatic check_final();
    chk("final_sum_ed", sum_ed, m_sum);
    chk("final_err_cnt", err_cnt, m_err);
    chk("final_max_ed", max_ed, m_max);
    chk("final_max_a", max_a, m_a);
    chk("final_max_b", max_b, m_b);
  endtask

  task automatic wait_done(input int exp_cyc);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    chk("done_seen", done, 1);
    chk("done_cycle", done_cyc, exp_cyc);
    chk("done_busy", busy, 0);
    chk("done_in_ready", in_ready, 0);
    check_final();
    tick();
    tick();
    chk("done_held", done, 1);
    check_final();
  endtask

  initial begin
    int p;
    int s0;
    model_clear();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_sum_ed", sum_ed, 0);
    chk("rst_max_ed", max_ed, 0);
    chk("rst_max_a", max_a, 0);
    chk("rst_max_b", max_b, 0);
    tick();

    // Exact samples, with the first offered together with start in IDLE.
    a = 8'd3; b = 8'd5; r = 16'd15; in_valid = 1'b1;
    start_batch(4);
    sa = '{3, 255, 0, 16}; sb = '{5, 255, 9, 16}; sr = '{15, 65025, 0, 256};
    feed();
    chk("b1_xfers", n_xfer, 4);
    wait_done(last_xfer + 3);
    chk("b1_sum_zero", sum_ed, 0);

    // Mixed errors: ED 25, 4, 0.
    start_batch(3);
    sa = '{15, 10, 7}; sb = '{15, 10, 8}; sr = '{200, 104, 56};
    feed();
    wait_done(last_xfer + 3);
    chk("b2_sum_ed", sum_ed, 29);
    chk("b2_err_cnt", err_cnt, 2);
    chk("b2_max_ed", max_ed, 25);
    chk("b2_max_a", max_a, 15);
    chk("b2_max_b", max_b, 15);

    // Tie on max ED keeps the first sample.
    start_batch(2);
    sa = '{2, 3}; sb = '{3, 2}; sr = '{0, 0};
    feed();
    wait_done(last_xfer + 3);
    chk("tie_max_ed", max_ed, 6);
    chk("tie_max_a", max_a, 2);
    chk("tie_max_b", max_b, 3);

    // in_valid held for 10 cycles against a 5-sample batch, plus a stray start mid-RUN.
    start_batch(5);
    for (int i = 0; i < 10; i++) begin
      p = (i + 1) * (2 * i + 3);
      a = WIDTH'(i + 1);
      b = WIDTH'(2 * i + 3);
      r = (2*WIDTH)'(p - (i % 3));
      in_valid = 1'b1;
      start = (i == 2);
      n_samples = CNT_W'(9);
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
    chk("bp_xfers", n_xfer, 5);
    chk("bp_in_ready_low", in_ready, 0);
    wait_done(last_xfer + 3);

    // Empty batch.
    ready_seen = 0;
    start_batch(0);
    s0 = cyc;
    wait_done(s0 + 1);
    chk("zero_no_ready", ready_seen, 0);
    chk("zero_sum", sum_ed, 0);

    // Reset in the middle of a batch.
    start_batch(5);
    sa = '{200, 100}; sb = '{3, 7}; sr = '{0, 1};
    feed();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    chk("mid_rst_sum_ed", sum_ed, 0);
    chk("mid_rst_max_ed", max_ed, 0);
    chk("mid_rst_max_a", max_a, 0);
    chk("mid_rst_max_b", max_b, 0);
    tick();
    chk("mid_rst_idle_busy", busy, 0);

    start_batch(1);
    sa = '{255}; sb = '{255}; sr = '{0};
    feed();
    wait_done(last_xfer + 3);
    chk("post_rst_sum", sum_ed, 65025);
    chk("post_rst_err", err_cnt, 1);
    chk("post_rst_max", max_ed, 65025);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
